// File: rtl/spi_host.sv
// spi_host: AXI-Stream command bytes in, cs_n-framed byte-wide SPI out (cs_n, mosi, miso), responses to real bytes out on m_axis, plus underrun/busy
module spi_host #(
  parameter int         READ_LATENCY = 1,
  parameter int         CS_GAP       = 2,
  parameter logic [7:0] FILL         = 8'h00
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tlast,
  output logic       cs_n,
  output logic [7:0] mosi,
  input  logic [7:0] miso,
  output logic       m_axis_tvalid,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tlast,
  output logic       underrun,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, GAP} state_t;
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [7:0] mosi_d;
  logic cs_n_d, underrun_d, real_d, last_d;
  logic [READ_LATENCY:0] real_q, last_q;
  assign s_axis_tready = state == IDLE || state == ACTIVE;
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    cs_n_d = cs_n;
    mosi_d = mosi;
    underrun_d = 1'b0;
    real_d = 1'b0;
    last_d = 1'b0;
    case (state)
      IDLE, ACTIVE:
        if (s_axis_tvalid) begin
          mosi_d = s_axis_tdata;
          cs_n_d = 1'b0;
          real_d = 1'b1;
          last_d = s_axis_tlast;
          cnt_d = 4'd0;
          state_d = s_axis_tlast ? DRAIN : ACTIVE;
        end else if (state == ACTIVE) begin
          mosi_d = FILL;
          underrun_d = 1'b1;
        end
      DRAIN: begin
        mosi_d = FILL;
        cnt_d = cnt + 4'd1;
        if (cnt == 4'(READ_LATENCY)) begin
          cs_n_d = 1'b1;
          cnt_d = 4'd0;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt + 4'd1;
        if (cnt == 4'(CS_GAP - 1)) begin
          cnt_d = 4'd0;
          state_d = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      cnt <= 4'd0;
      cs_n <= 1'b1;
      mosi <= 8'h00;
      underrun <= 1'b0;
      real_q <= '0;
      last_q <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= 8'h00;
      m_axis_tlast <= 1'b0;
    end else begin
      cnt <= cnt_d;
      cs_n <= cs_n_d;
      mosi <= mosi_d;
      underrun <= underrun_d;
      real_q <= {real_q[READ_LATENCY-1:0], real_d};
      last_q <= {last_q[READ_LATENCY-1:0], last_d};
      m_axis_tvalid <= real_q[READ_LATENCY];
      m_axis_tlast <= real_q[READ_LATENCY] & last_q[READ_LATENCY];
      if (real_q[READ_LATENCY]) m_axis_tdata <= miso;
    end
endmodule

// File: tb/tb_spi_host.sv
// tb_spi_host: directed and random frames on two spi_host instances (READ_LATENCY 1 and 3, loopback peripherals) checked cycle by cycle against a frame-level timing model
module tb_spi_host;
  localparam int GAP = 2;
  localparam logic [7:0] FILL = 8'h00;
  localparam logic [21:0] IDLE_OBS = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  logic tv[2], tl[2], tr[2], cs[2], mv[2], ml[2], und[2], bsy[2];
  logic [7:0] td[2], mo[2], md[2];
  logic [7:0] lb0 = 8'h00, lb1a = 8'h00, lb1b = 8'h00, lb1c = 8'h00;
  logic [21:0] t_obs[1024];
  logic [21:0] e_obs[1024];
  int ncyc, ntot, nfail;
  logic [7:0] it_b[$];
  int it_g[$];
  logic it_l[$];
  int fr_offer[$];

  always #5 aclk = ~aclk;
  always @(posedge aclk) begin
    lb0 <= mo[0];
    lb1a <= mo[1];
    lb1b <= lb1a;
    lb1c <= lb1b;
  end

  spi_host #(.READ_LATENCY(1), .CS_GAP(GAP), .FILL(FILL)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tvalid(tv[0]), .s_axis_tready(tr[0]),
    .s_axis_tdata(td[0]), .s_axis_tlast(tl[0]), .cs_n(cs[0]), .mosi(mo[0]), .miso(lb0),
    .m_axis_tvalid(mv[0]), .m_axis_tdata(md[0]), .m_axis_tlast(ml[0]),
    .underrun(und[0]), .busy(bsy[0]));
  spi_host #(.READ_LATENCY(3), .CS_GAP(GAP), .FILL(FILL)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tvalid(tv[1]), .s_axis_tready(tr[1]),
    .s_axis_tdata(td[1]), .s_axis_tlast(tl[1]), .cs_n(cs[1]), .mosi(mo[1]), .miso(lb1c),
    .m_axis_tvalid(mv[1]), .m_axis_tdata(md[1]), .m_axis_tlast(ml[1]),
    .underrun(und[1]), .busy(bsy[1]));

  // packed sample: [21]cs_n [20]underrun [19]m_valid [18]m_last [17]tready [16]busy [15:8]mosi [7:0]m_data
  function automatic logic [21:0] obs(input int d);
    return {cs[d], und[d], mv[d], mv[d] & ml[d], tr[d], bsy[d], mo[d], mv[d] ? md[d] : 8'h00};
  endfunction

  task automatic tick(input int d);
    @(negedge aclk);
    if (ncyc < 1024) t_obs[ncyc] = obs(d);
    ncyc++;
  endtask

  task automatic clear_items();
    it_b.delete();
    it_g.delete();
    it_l.delete();
  endtask

  task automatic add(input logic [7:0] b, input int g, input logic l);
    it_b.push_back(b);
    it_g.push_back(g);
    it_l.push_back(l);
  endtask

  task automatic drive(input int d, input int post);
    int w;
    ncyc = 0;
    fr_offer.delete();
    tick(d);
    for (int i = 0; i < it_b.size(); i++) begin
      repeat (it_g[i]) begin
        tv[d] = 1'b0;
        tick(d);
      end
      tv[d] = 1'b1;
      td[d] = it_b[i];
      tl[d] = it_l[i];
      if (i == 0 || it_l[i-1]) fr_offer.push_back(ncyc - 1);
      w = 0;
      while (!t_obs[ncyc-1][17] && w < 100) begin
        tick(d);
        w++;
      end
      if (w == 100) begin
        ntot++;
        nfail++;
        $display("FAIL drive_wait dut%0d: tready=0 after 100 cycles, want 1", d);
      end
      tick(d);
    end
    tv[d] = 1'b0;
    tl[d] = 1'b0;
    repeat (post) tick(d);
  endtask

  function automatic void eb(input int t, input int b, input logic v);
    if (t >= 0 && t < 1024) e_obs[t][b] = v;
  endfunction

  function automatic void ebyte(input int t, input int lo, input logic [7:0] v);
    if (t >= 0 && t < 1024) e_obs[t][lo +: 8] = v;
  endfunction

  // Frame-level model: a frame starts one cycle after it is offered or GAP+1 cycles after the
  // previous cs_n rise; its mosi is the bytes with mid-frame gaps as filler plus RL drain fillers.
  task automatic build_exp(input int d);
    int rl, f, pf, pl, p, i, pos_last, len;
    rl = d ? 3 : 1;
    for (int t = 0; t < 1024; t++) e_obs[t] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FILL, 8'h00};
    pf = -100;
    pl = 0;
    i = 0;
    for (int j = 0; j < fr_offer.size(); j++) begin
      f = (fr_offer[j] + 1 > pf + pl + GAP + 1) ? fr_offer[j] + 1 : pf + pl + GAP + 1;
      p = 0;
      pos_last = 0;
      do begin
        if (p > 0) repeat (it_g[i]) begin
          eb(f + p, 20, 1'b1);
          p++;
        end
        ebyte(f + p, 8, it_b[i]);
        eb(f + p + rl + 1, 19, 1'b1);
        eb(f + p + rl + 1, 18, it_l[i]);
        ebyte(f + p + rl + 1, 0, it_b[i]);
        if (it_l[i]) pos_last = p;
        p++;
        i++;
      end while (!it_l[i-1]);
      len = p + rl;
      for (int t = f; t < f + len; t++) eb(t, 21, 1'b0);
      for (int t = f; t < f + len + GAP; t++) eb(t, 16, 1'b1);
      for (int t = f + pos_last; t < f + len + GAP; t++) eb(t, 17, 1'b0);
      pf = f;
      pl = len;
    end
  endtask

  task automatic test_reset();
    #1 aresetn = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      ntot++;
      if ({obs(d), md[d], ml[d]} !== {IDLE_OBS, 8'h00, 1'b0}) begin
        nfail++;
        $display("FAIL reset_values dut%0d: got %h want %h", d, {obs(d), md[d], ml[d]}, {IDLE_OBS, 8'h00, 1'b0});
      end
    end
    @(negedge aclk) aresetn = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ncyc = 0;
      repeat (10) tick(d);
      for (int t = 0; t < ncyc; t++) begin
        ntot++;
        if (t_obs[t] !== IDLE_OBS) begin
          nfail++;
          $display("FAIL idle dut%0d cycle %0d: got %h want %h", d, t, t_obs[t], IDLE_OBS);
        end
      end
    end
  endtask

  task automatic test_frame3();
    for (int d = 0; d < 2; d++) begin
      clear_items();
      add(8'hA5, 0, 1'b0);
      add(8'h3C, 0, 1'b0);
      add(8'h7E, 0, 1'b1);
      drive(d, 10);
      build_exp(d);
      for (int t = 0; t < ncyc; t++) begin
        ntot++;
        if (t_obs[t] !== e_obs[t]) begin
          nfail++;
          $display("FAIL frame3 dut%0d cycle %0d: got %h want %h", d, t, t_obs[t], e_obs[t]);
        end
      end
    end
  endtask

  task automatic test_underrun();
    for (int d = 0; d < 2; d++) begin
      clear_items();
      add(8'h11, 0, 1'b0);
      add(8'h22, 2, 1'b1);
      drive(d, 10);
      build_exp(d);
      for (int t = 0; t < ncyc; t++) begin
        ntot++;
        if (t_obs[t] !== e_obs[t]) begin
          nfail++;
          $display("FAIL underrun dut%0d cycle %0d: got %h want %h", d, t, t_obs[t], e_obs[t]);
        end
      end
    end
  endtask

  task automatic test_single();
    for (int d = 0; d < 2; d++) begin
      clear_items();
      add(8'h5A, 0, 1'b1);
      drive(d, 10);
      build_exp(d);
      for (int t = 0; t < ncyc; t++) begin
        ntot++;
        if (t_obs[t] !== e_obs[t]) begin
          nfail++;
          $display("FAIL single dut%0d cycle %0d: got %h want %h", d, t, t_obs[t], e_obs[t]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      clear_items();
      add(8'h01, 0, 1'b0);
      add(8'h02, 0, 1'b1);
      add(8'h03, 0, 1'b1);
      drive(d, 10);
      build_exp(d);
      for (int t = 0; t < ncyc; t++) begin
        ntot++;
        if (t_obs[t] !== e_obs[t]) begin
          nfail++;
          $display("FAIL back_to_back dut%0d cycle %0d: got %h want %h", d, t, t_obs[t], e_obs[t]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int d = 0; d < 2; d++) begin
      ncyc = 0;
      tick(d);
      tv[d] = 1'b1;
      td[d] = 8'hC1;
      tl[d] = 1'b0;
      tick(d);
      td[d] = 8'hC2;
      tick(d);
      ntot++;
      if (mo[d] !== 8'hC2) begin
        nfail++;
        $display("FAIL midreset_setup dut%0d: mosi got %h want c2", d, mo[d]);
      end
      td[d] = 8'hC3;
      #2 aresetn = 1'b0;
      #1;
      ntot++;
      if ({cs[d], bsy[d], mv[d], ml[d]} !== 4'b1000) begin
        nfail++;
        $display("FAIL midreset_async dut%0d: cs_n/busy/valid/last got %b want 1000", d, {cs[d], bsy[d], mv[d], ml[d]});
      end
      tv[d] = 1'b0;
      @(negedge aclk);
      @(negedge aclk) aresetn = 1'b1;
      ncyc = 0;
      repeat (6) tick(d);
      for (int t = 0; t < ncyc; t++) begin
        ntot++;
        if (t_obs[t] !== IDLE_OBS) begin
          nfail++;
          $display("FAIL midreset_quiet dut%0d cycle %0d: got %h want %h", d, t, t_obs[t], IDLE_OBS);
        end
      end
      clear_items();
      add(8'h11, 0, 1'b0);
      add(8'h22, 2, 1'b1);
      drive(d, 10);
      build_exp(d);
      for (int t = 0; t < ncyc; t++) begin
        ntot++;
        if (t_obs[t] !== e_obs[t]) begin
          nfail++;
          $display("FAIL midreset_after dut%0d cycle %0d: got %h want %h", d, t, t_obs[t], e_obs[t]);
        end
      end
    end
  endtask

  task automatic test_random();
    int nf, nb;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 4; r++) begin
        clear_items();
        nf = int'($urandom_range(1, 3));
        for (int f = 0; f < nf; f++) begin
          nb = int'($urandom_range(1, 5));
          for (int b = 0; b < nb; b++)
            add(8'($urandom), b == 0 ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2)), b == nb - 1);
        end
        drive(d, 10);
        build_exp(d);
        for (int t = 0; t < ncyc; t++) begin
          ntot++;
          if (t_obs[t] !== e_obs[t]) begin
            nfail++;
            $display("FAIL random dut%0d round %0d cycle %0d: got %h want %h", d, r, t, t_obs[t], e_obs[t]);
          end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    ntot = 0;
    nfail = 0;
    ncyc = 0;
    for (int d = 0; d < 2; d++) begin
      tv[d] = 1'b0;
      tl[d] = 1'b0;
      td[d] = 8'h00;
    end
    test_reset();
    test_frame3();
    test_underrun();
    test_single();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", ntot, nfail);
    $finish;
  end
endmodule
